// File: rtl/md_unit_pkg.sv
// md_unit_pkg
// Shared definitions for the EX-stage multiply/divide unit.
//   md_op_e     : md_op encodings (sit beside the alu_* codes of the pipeline)
//   md_state_e  : control FSM states
//   *_DEFAULT   : default busy-cycle counts for mult/multu and div/divu
//   CNT_W       : width of the busy-cycle down-counter
package md_unit_pkg;

   typedef enum logic [3:0] {
      md_none  = 4'd0,
      md_mult  = 4'd1,
      md_multu = 4'd2,
      md_div   = 4'd3,
      md_divu  = 4'd4,
      md_mfhi  = 4'd5,
      md_mflo  = 4'd6,
      md_mthi  = 4'd7,
      md_mtlo  = 4'd8
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEFAULT = 5;
   localparam int DIV_CYCLES_DEFAULT  = 10;
   localparam int CNT_W               = 16;

   // Only the four arithmetic ops launch a multi-cycle operation.
   function automatic logic is_start_op(md_op_e op);
      return (op == md_mult) || (op == md_multu) || (op == md_div) || (op == md_divu);
   endfunction

   function automatic logic is_div_op(md_op_e op);
      return (op == md_div) || (op == md_divu);
   endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc
// Combinational datapath producing the 64-bit {HI, LO} result for an op.
//   op          : md operation (only mult/multu/div/divu produce a result)
//   d1, d2      : operands rs / rt
//   result      : {HI, LO}; for divides HI = remainder, LO = quotient
//   div_by_zero : high when d2 is zero (result is then meaningless)
module md_calc
   import md_unit_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [31:0] divisor;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic        neg_q;
   logic        neg_r;

   // Signed divide is done on magnitudes and the signs restored afterwards.
   // This gives truncation toward zero with the remainder following the
   // dividend, and makes 0x80000000 / -1 fall out as LO=0x80000000, HI=0
   // without relying on overflow behaviour of the '/' operator.
   always_comb begin
      result      = 64'd0;
      div_by_zero = (d2 == 32'd0);
      a_ext       = {32'd0, d1};
      b_ext       = {32'd0, d2};
      mag1        = d1;
      mag2        = d2;
      neg_q       = 1'b0;
      neg_r       = 1'b0;

      if (op == md_mult) begin
         a_ext = {{32{d1[31]}}, d1};
         b_ext = {{32{d2[31]}}, d2};
      end

      if (op == md_div) begin
         mag1  = d1[31] ? (32'd0 - d1) : d1;
         mag2  = d2[31] ? (32'd0 - d2) : d2;
         neg_q = d1[31] ^ d2[31];
         neg_r = d1[31];
      end

      divisor = div_by_zero ? 32'd1 : mag2;
      q_mag   = mag1 / divisor;
      r_mag   = mag1 % divisor;

      case (op)
         md_mult, md_multu: result = a_ext * b_ext;
         md_div, md_divu:   result = {neg_r ? (32'd0 - r_mag) : r_mag,
                                      neg_q ? (32'd0 - q_mag) : q_mag};
         default:           result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// md_unit
// Multi-cycle multiply/divide unit living beside the ALU in EX. Owns HI/LO.
//   clk    : pipeline clock
//   reset  : asynchronous, active-low reset
//   d1, d2 : forwarded rs / rt operands
//   md_op  : md operation code (md_op_e)
//   start  : launch request for mult/multu/div/divu
//   busy   : operation in flight; hazard unit stalls later md instructions
//   hi, lo : committed HI / LO registers
//   md_out : HI for mfhi, LO for mflo, otherwise 0 (combinational)
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [3:0]  md_op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   md_op_e          op;
   md_state_e       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic            busy_q,      busy_d;
   logic [31:0]     hi_q,        hi_d;
   logic [31:0]     lo_q,        lo_d;
   logic [31:0]     shadow_hi_q, shadow_hi_d;
   logic [31:0]     shadow_lo_q, shadow_lo_d;
   logic [63:0]     calc_result;
   logic            calc_div_by_zero;
   logic            accept;

   assign op = md_op_e'(md_op);

   md_calc u_calc (
      .op          (op),
      .d1          (d1),
      .d2          (d2),
      .result      (calc_result),
      .div_by_zero (calc_div_by_zero)
   );

   assign accept = start && !busy_q && is_start_op(op);

   // Next-state logic. A divide by zero latches the current HI/LO into the
   // shadow registers so the commit edge leaves them unchanged. HI/LO cannot
   // move while busy (mthi/mtlo are ignored then), so the snapshot stays valid.
   // The counter is loaded with N and the commit happens on the edge where it
   // would step from 1 to 0, giving exactly N busy cycles.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      shadow_hi_d = shadow_hi_q;
      shadow_lo_d = shadow_lo_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
               cnt_d   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               if (is_div_op(op) && calc_div_by_zero) begin
                  shadow_hi_d = hi_q;
                  shadow_lo_d = lo_q;
               end else begin
                  shadow_hi_d = calc_result[63:32];
                  shadow_lo_d = calc_result[31:0];
               end
            end else if (op == md_mthi) begin
               hi_d = d1;
            end else if (op == md_mtlo) begin
               lo_d = d1;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
               hi_d    = shadow_hi_q;
               lo_d    = shadow_lo_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // All state, including the registered busy output, in one flop block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         shadow_hi_q <= 32'd0;
         shadow_lo_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         shadow_hi_q <= shadow_hi_d;
         shadow_lo_q <= shadow_lo_d;
      end
   end

   assign busy   = busy_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign md_out = (op == md_mfhi) ? hi_q :
                   (op == md_mflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
// Directed testbench for md_unit. Stimulus pushes the expected HI/LO and busy
// length of every arithmetic op into a scoreboard queue; a monitor pops an
// entry each time busy falls (commit) and compares. Register writes, md_out
// and reset behaviour are compared directly.
module tb_md_unit;
   import md_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [3:0]  md_op;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      int          id;
   } exp_t;

   exp_t sb_q[$];

   md_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .d1     (d1),
      .d2     (d2),
      .md_op  (md_op),
      .start  (start),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo),
      .md_out (md_out)
   );

   // 10 time-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one instruction for exactly one rising edge, then returns to idle.
   // Called and returns at posedge+1.
   task automatic applyStimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic st);
      md_op = op;
      d1    = a;
      d2    = b;
      start = st;
      @(posedge clk);
      #1;
      md_op = md_none;
      start = 1'b0;
   endtask

   task automatic pushExpect(input int id, input logic [31:0] h, input logic [31:0] l, input int cyc);
      exp_t e;
      e.hi     = h;
      e.lo     = l;
      e.cycles = cyc;
      e.id     = id;
      sb_q.push_back(e);
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (busy === 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: busy still %b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   // Monitor: counts busy cycles on the falling edge and checks each commit.
   initial begin
      int   busy_cnt  = 0;
      logic busy_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            busy_cnt  = 0;
            busy_prev = 1'b0;
         end else begin
            if (busy === 1'b1) begin
               busy_cnt++;
            end else if (busy_prev) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected commit: hi=%h lo=%h with empty scoreboard", hi, lo);
               end else begin
                  e = sb_q.pop_front();
                  checkOutput($sformatf("op%0d hi", e.id), hi, e.hi);
                  checkOutput($sformatf("op%0d lo", e.id), lo, e.lo);
                  checkOutput($sformatf("op%0d busy cycles", e.id), 32'(busy_cnt), 32'(e.cycles));
               end
               busy_cnt = 0;
            end
            busy_prev = busy;
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      reset = 1'b0;
      d1    = 32'd0;
      d2    = 32'd0;
      md_op = md_none;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      checkOutput("reset md_out", md_out, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Signed and unsigned multiply of 0xFFFFFFFF * 2
      pushExpect(1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      applyStimulus(md_mult, 32'hFFFFFFFF, 32'd2, 1'b1);
      waitIdle("mult");
      pushExpect(2, 32'h00000001, 32'hFFFFFFFE, 5);
      applyStimulus(md_multu, 32'hFFFFFFFF, 32'd2, 1'b1);
      waitIdle("multu");

      // Signed divide -7 / 2 and unsigned 7 / 2
      pushExpect(3, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      applyStimulus(md_div, 32'hFFFFFFF9, 32'd2, 1'b1);
      waitIdle("div");
      pushExpect(4, 32'd1, 32'd3, 10);
      applyStimulus(md_divu, 32'd7, 32'd2, 1'b1);
      waitIdle("divu");

      // Divide by zero leaves HI/LO alone
      applyStimulus(md_mthi, 32'h11, 32'd0, 1'b0);
      applyStimulus(md_mtlo, 32'h22, 32'd0, 1'b0);
      checkOutput("mthi write", hi, 32'h11);
      checkOutput("mtlo write", lo, 32'h22);
      pushExpect(5, 32'h11, 32'h22, 10);
      applyStimulus(md_divu, 32'd7, 32'd0, 1'b1);
      waitIdle("divu by zero");

      // Signed overflow case
      pushExpect(6, 32'd0, 32'h80000000, 10);
      applyStimulus(md_div, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      waitIdle("div overflow");

      // Start and mthi while busy are both ignored
      pushExpect(7, 32'd0, 32'd12, 5);
      applyStimulus(md_mult, 32'd3, 32'd4, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(md_div, 32'd100, 32'd7, 1'b1);
      applyStimulus(md_mthi, 32'h55, 32'd0, 1'b0);
      waitIdle("mult with ignored start");
      @(posedge clk);
      #1;
      checkOutput("hi after ignored mthi", hi, 32'd0);

      // Asynchronous reset in the middle of a multiply
      applyStimulus(md_mult, 32'd5, 32'd6, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async reset busy", {31'd0, busy}, 32'd0);
      checkOutput("async reset hi", hi, 32'd0);
      checkOutput("async reset lo", lo, 32'd0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("post reset busy", {31'd0, busy}, 32'd0);
      checkOutput("post reset hi", hi, 32'd0);
      checkOutput("post reset lo", lo, 32'd0);

      // Move-to then move-from, and md_out selection
      applyStimulus(md_mthi, 32'h1234, 32'd0, 1'b0);
      applyStimulus(md_mtlo, 32'hABCD, 32'd0, 1'b0);
      md_op = md_mflo;
      #1;
      checkOutput("mflo md_out", md_out, 32'hABCD);
      md_op = md_mfhi;
      #1;
      checkOutput("mfhi md_out", md_out, 32'h1234);
      md_op = md_none;
      #1;
      checkOutput("none md_out", md_out, 32'd0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
